// File: rtl/asg_pkg.sv
// Shared constants, load-target encoding and the LFSR step helper for the
// alternating step generator keystream core.
package asg_pkg;

   localparam int          W0_DEF     = 5;
   localparam int          W1_DEF     = 7;
   localparam int          W2_DEF     = 11;
   localparam logic [4:0]  TAPS0_DEF  = 5'b10100;
   localparam logic [6:0]  TAPS1_DEF  = 7'b1100000;
   localparam logic [10:0] TAPS2_DEF  = 11'b10100000000;
   localparam int          OUT_W_DEF  = 8;
   localparam int          WARMUP_DEF = 32;
   localparam int          LFSR_MAX_W = 32;

   typedef enum logic [1:0] {
      SEL_R0  = 2'd0,
      SEL_R1  = 2'd1,
      SEL_R2  = 2'd2,
      SEL_ALL = 2'd3
   } sel_e;

   // Fibonacci step: feedback is the parity of the tapped bits, shifted in at the LSB.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                       input logic [LFSR_MAX_W-1:0] taps,
                                                       input int width);
      logic                  fb;
      logic [LFSR_MAX_W-1:0] mask;
      fb = ^(state & taps);
      if (width >= LFSR_MAX_W) mask = '1;
      else                     mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
      return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
   endfunction

endpackage

// File: rtl/asg_lfsr.sv
// One Fibonacci LFSR of the generator with serial seed loading and a
// zero-lock escape; msb_next previews the MSB the register would hold after a step.
module asg_lfsr
   import asg_pkg::*;
#(
   parameter int         W    = W0_DEF,
   parameter logic [W-1:0] TAPS = TAPS0_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   input  logic         load,
   input  logic         seed_bit,
   output logic [W-1:0] state,
   output logic         msb_next
);

   logic [W-1:0] state_q;
   logic [W-1:0] state_d;
   logic [W-1:0] stepped;

   always_comb begin
      // An all-zero register would never leave zero, so it is kicked to 1 instead.
      if (state_q == '0) stepped = W'(1);
      else               stepped = W'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS), W));
   end

   always_comb begin
      state_d = state_q;
      if (load)      state_d = {state_q[W-2:0], seed_bit};
      else if (step) state_d = stepped;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= '1;
      else        state_q <= state_d;
   end

   assign state    = state_q;
   assign msb_next = stepped[W-1];

endmodule

// File: rtl/asg_stream.sv
// Alternating step generator keystream core: R0 clocks either R1 or R2, the
// output bit is the XOR of their MSBs, packed LSB-first into OUT_W-bit words.
module asg_stream
   import asg_pkg::*;
#(
   parameter int            W0     = W0_DEF,
   parameter int            W1     = W1_DEF,
   parameter int            W2     = W2_DEF,
   parameter logic [W0-1:0] TAPS0  = TAPS0_DEF,
   parameter logic [W1-1:0] TAPS1  = TAPS1_DEF,
   parameter logic [W2-1:0] TAPS2  = TAPS2_DEF,
   parameter int            OUT_W  = OUT_W_DEF,
   parameter int            WARMUP = WARMUP_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       sel,
   input  logic             load,
   input  logic             seed_bit,
   input  logic             enable,
   output logic             bit_out,
   output logic             bit_valid,
   output logic [OUT_W-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             warm
);

   localparam int                WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int                CNT_W  = $clog2(OUT_W);
   localparam logic [CNT_W-1:0]  LAST   = CNT_W'(OUT_W - 1);

   logic [W0-1:0] r0_state;
   logic [W1-1:0] r1_state;
   logic [W2-1:0] r2_state;
   logic          r0_msb_next, r1_msb_next, r2_msb_next;
   logic          ld_r0, ld_r1, ld_r2;
   logic          c, ks, stall, gen_step, word_done;
   logic          unused_state_bits;

   logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OUT_W-2:0]  pack_q, pack_d;
   logic [OUT_W-1:0]  word_out_q, word_out_d;
   logic              word_valid_q, word_valid_d;
   logic              bit_out_q, bit_out_d;
   logic              bit_valid_q, bit_valid_d;

   assign ld_r0 = load & ((sel == SEL_R0) | (sel == SEL_ALL));
   assign ld_r1 = load & ((sel == SEL_R1) | (sel == SEL_ALL));
   assign ld_r2 = load & ((sel == SEL_R2) | (sel == SEL_ALL));

   assign warm     = (warm_cnt_q != '0);
   // Hold the generator only when the last free pack slot would complete a word with nowhere to go.
   assign stall    = word_valid_q & ~word_ready & (cnt_q == LAST) & ~warm;
   assign gen_step = enable & ~load & ~stall;
   assign c        = r0_state[W0-1];

   asg_lfsr #(.W(W0), .TAPS(TAPS0)) u_r0 (
      .clk(clk), .rst_n(rst_n), .step(gen_step), .load(ld_r0), .seed_bit(seed_bit),
      .state(r0_state), .msb_next(r0_msb_next)
   );
   asg_lfsr #(.W(W1), .TAPS(TAPS1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .step(gen_step & c), .load(ld_r1), .seed_bit(seed_bit),
      .state(r1_state), .msb_next(r1_msb_next)
   );
   asg_lfsr #(.W(W2), .TAPS(TAPS2)) u_r2 (
      .clk(clk), .rst_n(rst_n), .step(gen_step & ~c), .load(ld_r2), .seed_bit(seed_bit),
      .state(r2_state), .msb_next(r2_msb_next)
   );

   // The held register contributes its current MSB, the stepping one its post-step MSB.
   assign ks = (c ? r1_msb_next : r1_state[W1-1]) ^ (c ? r2_state[W2-1] : r2_msb_next);

   assign unused_state_bits = ^{r0_state[W0-2:0], r0_msb_next, r1_state[W1-2:0], r2_state[W2-2:0]};

   always_comb begin
      warm_cnt_d  = warm_cnt_q;
      cnt_d       = cnt_q;
      pack_d      = pack_q;
      word_out_d  = word_out_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      word_done   = 1'b0;
      if (load) begin
         warm_cnt_d = WCNT_W'(WARMUP);
         cnt_d      = '0;
      end else if (gen_step) begin
         if (warm) begin
            warm_cnt_d = warm_cnt_q - WCNT_W'(1);
         end else begin
            bit_out_d   = ks;
            bit_valid_d = 1'b1;
            if (cnt_q == LAST) begin
               word_out_d = {ks, pack_q};
               word_done  = 1'b1;
               cnt_d      = '0;
            end else begin
               pack_d[cnt_q] = ks;
               cnt_d         = cnt_q + CNT_W'(1);
            end
         end
      end
      word_valid_d = word_done | (word_valid_q & ~word_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt_q   <= WCNT_W'(WARMUP);
         cnt_q        <= '0;
         pack_q       <= '0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
      end else begin
         warm_cnt_q   <= warm_cnt_d;
         cnt_q        <= cnt_d;
         pack_q       <= pack_d;
         word_out_q   <= word_out_d;
         word_valid_q <= word_valid_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
      end
   end

   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign word_out   = word_out_q;
   assign word_valid = word_valid_q;

endmodule

// File: tb/tb_asg_stream.sv
// Bench for asg_stream: two instances (no warm-up, 32-step warm-up) driven in
// lockstep and checked against a behavioural keystream/packer model.
module tb_asg_stream;

   logic       clk, rst_n, load, seed_bit, enable, word_ready;
   logic [1:0] sel;
   logic [1:0] bo, bv, wv, wm;
   logic [7:0] wo [2];

   int n_cmp = 0;
   int n_fail = 0;

   asg_stream #(.WARMUP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .load(load), .seed_bit(seed_bit), .enable(enable),
      .bit_out(bo[0]), .bit_valid(bv[0]), .word_out(wo[0]), .word_valid(wv[0]),
      .word_ready(word_ready), .warm(wm[0])
   );
   asg_stream #(.WARMUP(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .load(load), .seed_bit(seed_bit), .enable(enable),
      .bit_out(bo[1]), .bit_valid(bv[1]), .word_out(wo[1]), .word_valid(wv[1]),
      .word_ready(word_ready), .warm(wm[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_r [2][3];
   int m_warm [2];
   int m_cnt [2];
   int m_part [2];
   int m_wout [2];
   bit m_wv [2];
   bit m_bo [2];
   bit m_bv [2];
   bit seq0 [6];

   function automatic int wid(int j);
      return (j == 0) ? 5 : (j == 1) ? 7 : 11;
   endfunction

   function automatic int taps(int j);
      return (j == 0) ? 32'h14 : (j == 1) ? 32'h60 : 32'h500;
   endfunction

   function automatic int warm_of(int k);
      return (k == 0) ? 0 : 32;
   endfunction

   function automatic int reg_step(int v, int j);
      int fb;
      int w;
      fb = 0;
      w = wid(j);
      if (v == 0) return 1;
      for (int i = 0; i < w; i++)
         if ((((taps(j) >> i) & 1) == 1) && (((v >> i) & 1) == 1)) fb ^= 1;
      return ((v << 1) | fb) & ((1 << w) - 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) m_r[k][j] = (1 << wid(j)) - 1;
         m_warm[k] = warm_of(k);
         m_cnt[k] = 0; m_part[k] = 0; m_wout[k] = 0;
         m_wv[k] = 0; m_bo[k] = 0; m_bv[k] = 0;
      end
   endtask

   task automatic model_cycle(input int k, input int s, input bit ld, input bit sd,
                              input bit en, input bit rdy);
      bit xfer, newword, stall, cbit, b;
      xfer = m_wv[k] && rdy;
      newword = 0;
      m_bv[k] = 0;
      if (ld) begin
         for (int j = 0; j < 3; j++)
            if (s == 3 || s == j) m_r[k][j] = ((m_r[k][j] << 1) | int'(sd)) & ((1 << wid(j)) - 1);
         m_warm[k] = warm_of(k);
         m_cnt[k] = 0; m_part[k] = 0;
      end else begin
         stall = m_wv[k] && !rdy && (m_cnt[k] == 7) && (m_warm[k] == 0);
         if (en && !stall) begin
            cbit = ((m_r[k][0] >> 4) & 1) == 1;
            m_r[k][0] = reg_step(m_r[k][0], 0);
            if (cbit) m_r[k][1] = reg_step(m_r[k][1], 1);
            else      m_r[k][2] = reg_step(m_r[k][2], 2);
            b = (((m_r[k][1] >> 6) ^ (m_r[k][2] >> 10)) & 1) == 1;
            if (m_warm[k] > 0) m_warm[k]--;
            else begin
               m_bo[k] = b; m_bv[k] = 1;
               m_part[k] |= int'(b) << m_cnt[k];
               m_cnt[k]++;
               if (m_cnt[k] == 8) begin
                  m_wout[k] = m_part[k]; m_wv[k] = 1; newword = 1;
                  m_cnt[k] = 0; m_part[k] = 0;
               end
            end
         end
      end
      if (xfer && !newword) m_wv[k] = 0;
   endtask

   task automatic tick(input int s, input bit ld, input bit sd, input bit en, input bit rdy);
      sel = 2'(s); load = ld; seed_bit = sd; enable = en; word_ready = rdy;
      model_cycle(0, s, ld, sd, en, rdy);
      model_cycle(1, s, ld, sd, en, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sel = 2'd0; load = 0; seed_bit = 0; enable = 0; word_ready = 0;
      rst_n = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sel = 2'd0; load = 0; seed_bit = 0; enable = 0; word_ready = 0;
      rst_n = 0;
      model_reset();
      #12;
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if ({bo[k], bv[k], wv[k]} !== 3'b000) begin
            n_fail++; $display("FAIL reset_bits dut%0d: got %b want 000", k, {bo[k], bv[k], wv[k]});
         end
         n_cmp++; if (wo[k] !== 8'h00) begin
            n_fail++; $display("FAIL reset_word dut%0d: got %h want 00", k, wo[k]);
         end
         n_cmp++; if (wm[k] !== (k == 1)) begin
            n_fail++; $display("FAIL reset_warm dut%0d: got %b want %b", k, wm[k], (k == 1));
         end
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_fixed_seq();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick(0, 0, 0, 1, 1);
         seq0[i] = bo[0];
         n_cmp++; if ({bv[0], bo[0]} !== 2'b10) begin
            n_fail++; $display("FAIL fixed_seq step %0d: got valid/bit %b want 10", i, {bv[0], bo[0]});
         end
         n_cmp++; if ({bv[1], wm[1]} !== 2'b01) begin
            n_fail++; $display("FAIL fixed_seq_warm step %0d: got valid/warm %b want 01", i, {bv[1], wm[1]});
         end
      end
   endtask

   task automatic test_zero_lock();
      int ones;
      int zeros;
      bit en, rdy;
      ones = 0; zeros = 0;
      for (int i = 0; i < 11; i++) tick(3, 1, 0, 0, 1);
      for (int i = 0; i < 260; i++) begin
         en = (i == 0) || ($urandom_range(3) != 0);
         rdy = $urandom_range(1) == 1;
         tick(0, 0, 0, en, rdy);
         if (i == 0) begin
            n_cmp++; if ({int'(dut0.u_r0.state), int'(dut0.u_r1.state), int'(dut0.u_r2.state)} !==
                         {m_r[0][0], m_r[0][1], m_r[0][2]}) begin
               n_fail++; $display("FAIL zl_state: got %h/%h/%h want %h/%h/%h", dut0.u_r0.state,
                  dut0.u_r1.state, dut0.u_r2.state, m_r[0][0], m_r[0][1], m_r[0][2]);
            end
         end
         if (bv[0] === 1'b1) begin
            if (bo[0] === 1'b1) ones++; else zeros++;
         end
         for (int k = 0; k < 2; k++) begin
            n_cmp++; if (bv[k] !== m_bv[k]) begin
               n_fail++; $display("FAIL zl_valid dut%0d cyc %0d: got %b want %b", k, i, bv[k], m_bv[k]);
            end
            if (m_bv[k]) begin
               n_cmp++; if (bo[k] !== m_bo[k]) begin
                  n_fail++; $display("FAIL zl_bit dut%0d cyc %0d: got %b want %b", k, i, bo[k], m_bo[k]);
               end
            end
            n_cmp++; if (wv[k] !== m_wv[k]) begin
               n_fail++; $display("FAIL zl_wvalid dut%0d cyc %0d: got %b want %b", k, i, wv[k], m_wv[k]);
            end
            if (m_wv[k]) begin
               n_cmp++; if (wo[k] !== 8'(m_wout[k])) begin
                  n_fail++; $display("FAIL zl_word dut%0d cyc %0d: got %h want %h", k, i, wo[k], 8'(m_wout[k]));
               end
            end
         end
      end
      n_cmp++; if (ones == 0 || zeros == 0) begin
         n_fail++; $display("FAIL zl_stuck: got ones=%0d zeros=%0d want both nonzero", ones, zeros);
      end
   endtask

   task automatic test_warmup();
      int pulses;
      pulses = 0;
      do_reset();
      tick($urandom_range(3), 1, $urandom_range(1) == 1, 1, 0);
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, 0, 1, 0);
         if (bv[1] === 1'b1) pulses++;
         for (int k = 0; k < 2; k++) begin
            n_cmp++; if (wm[k] !== (m_warm[k] != 0)) begin
               n_fail++; $display("FAIL wu_warm dut%0d cyc %0d: got %b want %b", k, i, wm[k], (m_warm[k] != 0));
            end
            n_cmp++; if (bv[k] !== m_bv[k]) begin
               n_fail++; $display("FAIL wu_valid dut%0d cyc %0d: got %b want %b", k, i, bv[k], m_bv[k]);
            end
            if (m_bv[k]) begin
               n_cmp++; if (bo[k] !== m_bo[k]) begin
                  n_fail++; $display("FAIL wu_bit dut%0d cyc %0d: got %b want %b", k, i, bo[k], m_bo[k]);
               end
            end
            if (m_wv[k]) begin
               n_cmp++; if (wo[k] !== 8'(m_wout[k])) begin
                  n_fail++; $display("FAIL wu_word dut%0d cyc %0d: got %h want %h", k, i, wo[k], 8'(m_wout[k]));
               end
            end
         end
      end
      n_cmp++; if (pulses != 8) begin
         n_fail++; $display("FAIL wu_pulses: got %0d want 8", pulses);
      end
      n_cmp++; if (wv[1] !== 1'b1) begin
         n_fail++; $display("FAIL wu_word_valid: got %b want 1", wv[1]);
      end
   endtask

   task automatic test_back_to_back();
      int bits;
      logic [7:0] held;
      bits = 0;
      held = '0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         tick(0, 0, 0, 1, 0);
         if (bv[0] === 1'b1) bits++;
         if (i == 7) held = wo[0];
      end
      n_cmp++; if (bits != 15) begin
         n_fail++; $display("FAIL stall_bits: got %0d want 15", bits);
      end
      n_cmp++; if (wo[0] !== 8'(m_wout[0]) || wo[0] !== held) begin
         n_fail++; $display("FAIL stall_word: got %h want %h (first word %h)", wo[0], 8'(m_wout[0]), held);
      end
      for (int i = 0; i < 40; i++) begin
         tick(0, 0, 0, 1, (i == 0) ? 1'b1 : ($urandom_range(2) == 0));
         for (int k = 0; k < 2; k++) begin
            n_cmp++; if (bv[k] !== m_bv[k]) begin
               n_fail++; $display("FAIL b2b_valid dut%0d cyc %0d: got %b want %b", k, i, bv[k], m_bv[k]);
            end
            if (m_bv[k]) begin
               n_cmp++; if (bo[k] !== m_bo[k]) begin
                  n_fail++; $display("FAIL b2b_bit dut%0d cyc %0d: got %b want %b", k, i, bo[k], m_bo[k]);
               end
            end
            n_cmp++; if (wv[k] !== m_wv[k]) begin
               n_fail++; $display("FAIL b2b_wvalid dut%0d cyc %0d: got %b want %b", k, i, wv[k], m_wv[k]);
            end
            if (m_wv[k]) begin
               n_cmp++; if (wo[k] !== 8'(m_wout[k])) begin
                  n_fail++; $display("FAIL b2b_word dut%0d cyc %0d: got %h want %h", k, i, wo[k], 8'(m_wout[k]));
               end
            end
         end
      end
   endtask

   task automatic test_load_mid();
      do_reset();
      for (int i = 0; i < 13; i++) tick(0, 0, 0, 1, 0);
      n_cmp++; if ({wv[0], dut0.cnt_q} !== {1'b1, 3'd5}) begin
         n_fail++; $display("FAIL lm_setup: got valid/cnt %b/%0d want 1/5", wv[0], dut0.cnt_q);
      end
      tick($urandom_range(3), 1, $urandom_range(1) == 1, 1, 0);
      n_cmp++; if (bv !== 2'b00) begin
         n_fail++; $display("FAIL lm_load_wins: got bit_valid %b want 00", bv);
      end
      n_cmp++; if (wv[0] !== 1'b1) begin
         n_fail++; $display("FAIL lm_keep_word: got %b want 1", wv[0]);
      end
      n_cmp++; if (dut0.cnt_q !== 3'd0) begin
         n_fail++; $display("FAIL lm_cnt_clear: got %0d want 0", dut0.cnt_q);
      end
      n_cmp++; if (dut1.warm_cnt_q !== 6'd32) begin
         n_fail++; $display("FAIL lm_warm_restart: got %0d want 32", dut1.warm_cnt_q);
      end
      for (int i = 0; i < 45; i++) begin
         tick(0, 0, 0, 1, 0);
         for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({bv[k], wv[k], wm[k]} !== {m_bv[k], m_wv[k], (m_warm[k] != 0)}) begin
               n_fail++; $display("FAIL lm_ctrl dut%0d cyc %0d: got %b want %b", k, i, {bv[k], wv[k], wm[k]},
                  {m_bv[k], m_wv[k], (m_warm[k] != 0)});
            end
            if (m_bv[k]) begin
               n_cmp++; if (bo[k] !== m_bo[k]) begin
                  n_fail++; $display("FAIL lm_bit dut%0d cyc %0d: got %b want %b", k, i, bo[k], m_bo[k]);
               end
            end
            if (m_wv[k]) begin
               n_cmp++; if (wo[k] !== 8'(m_wout[k])) begin
                  n_fail++; $display("FAIL lm_word dut%0d cyc %0d: got %h want %h", k, i, wo[k], 8'(m_wout[k]));
               end
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 0);
      #2;
      rst_n = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if ({bo[k], bv[k], wv[k], wo[k]} !== 11'd0) begin
            n_fail++; $display("FAIL ar_clear dut%0d: got %b/%b/%b/%h want all zero", k, bo[k], bv[k], wv[k], wo[k]);
         end
         n_cmp++; if (wm[k] !== (k == 1)) begin
            n_fail++; $display("FAIL ar_warm dut%0d: got %b want %b", k, wm[k], (k == 1));
         end
      end
      model_reset();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         tick(0, 0, 0, 1, 1);
         n_cmp++; if ({bv[0], bo[0]} !== {1'b1, seq0[i]}) begin
            n_fail++; $display("FAIL ar_repeat step %0d: got %b want %b", i, {bv[0], bo[0]}, {1'b1, seq0[i]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_seq();
      test_zero_lock();
      test_warmup();
      test_back_to_back();
      test_load_mid();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/asg_stream.md
Name: asg_stream

Overview:
- Parametrised alternating step generator (ASG) keystream core, successor to the fixed-size ASG used in the TinyTapeout top.
- Three Fibonacci LFSRs: R0 is the control register, R1 and R2 are the data registers. Every LFSR width and tap mask is a parameter.
- Adds: per-register serial seed loading, a post-load warm-up discard counter, and an OUT_W-bit word packer with a valid/ready handshake that stalls the generator on back-pressure.
- Sits between the pad-level wrapper (ui_in/uo_out) and any downstream consumer of the keystream.

Parameters:
- W0, 5, width of control LFSR R0
- W1, 7, width of data LFSR R1
- W2, 11, width of data LFSR R2
- TAPS0, 5'b10100, R0 feedback mask (x^5+x^3+1)
- TAPS1, 7'b1100000, R1 feedback mask (x^7+x^6+1)
- TAPS2, 11'b10100000000, R2 feedback mask (x^11+x^9+1)
- OUT_W, 8, packed word width, must be >=2
- WARMUP, 32, steps discarded after any load; 0 disables warm-up

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  2  load target: 0=R0, 1=R1, 2=R2, 3=all three
- load  in  1  shift seed_bit into the selected register(s) this cycle
- seed_bit  in  1  serial seed data
- enable  in  1  request one generator step this cycle
- bit_out  out  1  latest keystream bit
- bit_valid  out  1  one-cycle pulse, bit_out is new
- word_out  out  OUT_W  packed keystream word, first bit in the LSB
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out
- warm  out  1  high while warm-up discarding is active

Behaviour:
- Reset (async, rst_n=0):
  - R0, R1 and R2 are all-ones.
  - Warm-up counter = WARMUP; warm = (WARMUP!=0).
  - Pack counter = 0.
  - bit_out, bit_valid, word_out and word_valid are all 0.
- LFSR step: fb = ^(s & TAPS); s_next = {s[W-2:0], fb}; output bit = s[W-1].
- Generator step, all updates on one edge:
  - c = R0[W0-1] before the step; R0 always steps.
  - c=1: R1 steps and R2 holds. c=0: R2 steps and R1 holds.
  - Keystream bit = R1_next[W1-1] ^ R2_next[W2-1].
- Zero-lock guard: a register in the all-zero state loads 1 instead of stepping. This applies only to registers that step.
- Load has priority over enable:
  - While load=1, s <= {s[W-2:0], seed_bit} for each selected register. No generator step occurs and bit_valid=0.
  - While load=1, the warm-up counter reloads WARMUP and the pack counter clears. A pending word_valid is kept.
- Step condition: enable & !load & !stall.
  - stall = word_valid & !word_ready & (pack count == OUT_W-1) & !warm.
  - Packing is lossless: the generator never produces a bit it cannot store.
- Warm-up state (counter != 0):
  - Each step decrements the counter.
  - bit_valid stays 0 and nothing is packed.
  - warm falls on the edge where the counter reaches 0.
- Run state (counter == 0):
  - Each step sets bit_out and pulses bit_valid=1 for one cycle, latency 1 edge after the enabled cycle.
  - The bit is written to pack[cnt] and cnt increments.
  - At cnt==OUT_W-1 the completed word goes to word_out, word_valid sets and cnt wraps to 0.
- Handshake:
  - word_valid clears on a cycle with word_valid & word_ready and no new word completing.
  - If a new word completes in the same cycle as the transfer, word_out is replaced and word_valid stays 1.
  - word_out is stable while word_valid & !word_ready.
- enable=0: all state holds and bit_valid=0.
- Reset mid-operation: reset takes effect immediately and discards the partial word.

Decomposition:
- Package asg_pkg: the default width/tap constants, the sel encoding (SEL_R0, SEL_R1, SEL_R2, SEL_ALL) and a function lfsr_next(state, taps, width).
- Sub-module asg_lfsr, instantiated three times. Parameters W and TAPS; ports step, load, seed_bit, state, msb_next.
- Warm-up counter, packer and stall logic live in asg_stream.

Test Plan:
- Reset, WARMUP=0, enable=1 for 6 cycles -> bit_valid pulses each cycle, bit_out sequence 0,0,0,0,0,0, with R1 stepping on steps 1-5 and R2 on step 6.
- Load sel=3 with 11 seed bits of 0 (all registers zero), then step -> zero-lock guard fires, state LSBs become 1 and there is no stuck-zero output. Compare against the C model for 200 bits.
- WARMUP=32, load one bit, enable 40 cycles -> no bit_valid and warm=1 for the first 32 steps, then 8 bits produced and one word with word_valid=1.
- word_ready=0, enable=1 continuously -> after 2*OUT_W-1 bits the generator stalls with word_out stable. Raise word_ready for 1 cycle -> generation resumes with no lost or duplicated bits versus the model.
- load asserted in the middle of a word (cnt=5) -> cnt clears, warm-up restarts, the pending word_valid is kept, and load wins over a simultaneous enable.
- rst_n pulled low asynchronously mid-stream -> outputs clear before the next clk edge, and after release the stream repeats the post-reset sequence exactly.
